// File: rtl/execution_controller.sv
// Sequences the single-cycle computer: turns step presses, rate ticks, bursts and
// breakpoints into registered one-cycle cpu_enable pulses and counts executed cycles.
module execution_controller #(
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic [1:0]             mode_i,
    input  logic                   step_req_i,
    input  logic                   tick_i,
    input  logic [BURST_WIDTH-1:0] burst_len_i,
    input  logic                   bp_enable_i,
    input  logic [PC_WIDTH-1:0]    bp_addr_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic                   cpu_enable_o,
    output logic                   register_reset_o,
    output logic [COUNT_WIDTH-1:0] cycle_count_o,
    output logic [1:0]             state_o,
    output logic                   halted_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_BURST = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    localparam logic [1:0] MODE_STEP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    state_e                 state_q, state_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   step_q;
    logic                   enable_q;
    logic                   reg_reset_q;
    logic                   halted_q;
    logic                   step_edge;
    logic                   bp_hit;
    logic                   fire;

    assign step_edge = step_req_i & ~step_q;
    assign bp_hit    = bp_enable_i && (pc_i == bp_addr_i);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fire        = 1'b0;
        if (clear_i) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mode_i == MODE_STEP && step_edge) begin
                        fire = 1'b1;
                    end else if (mode_i == MODE_RUN) begin
                        state_d = S_RUN;
                    end else if (mode_i == MODE_BURST && step_edge && burst_len_i != '0) begin
                        remaining_d = burst_len_i;
                        state_d     = S_BURST;
                    end
                end
                S_RUN: begin
                    // Leaving run mode wins over a tick arriving in the same cycle.
                    if (mode_i != MODE_RUN) begin
                        state_d = S_IDLE;
                    end else if (tick_i) begin
                        if (bp_hit) state_d = S_HALT;
                        else        fire    = 1'b1;
                    end
                end
                S_BURST: begin
                    if (mode_i == MODE_HOLD) begin
                        state_d     = S_IDLE;
                        remaining_d = '0;
                    end else if (tick_i) begin
                        // Breakpoint keeps remaining so the burst length is still visible.
                        if (bp_hit) begin
                            state_d = S_HALT;
                        end else begin
                            fire        = 1'b1;
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == BURST_WIDTH'(1)) state_d = S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    if (step_edge) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        count_d = count_q;
        if (clear_i)   count_d = '0;
        else if (fire) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            step_q      <= 1'b0;
            enable_q    <= 1'b0;
            reg_reset_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            step_q      <= step_req_i;
            enable_q    <= fire;
            reg_reset_q <= fire && (count_q == '0);
            halted_q    <= (state_d == S_HALT);
        end
    end

    assign cpu_enable_o     = enable_q;
    assign register_reset_o = reg_reset_q;
    assign cycle_count_o    = count_q;
    assign state_o          = state_q;
    assign halted_o         = halted_q;

endmodule

// File: doc/execution_controller.md
Name: execution_controller

Overview:
Sequences the single-cycle computer from the 50 MHz system clock. It replaces direct gating of the computer clock with a registered one-cycle enable pulse. Supports manual single-step, free-run at a tick rate, fixed-length bursts and a PC breakpoint. It also owns the cycle counter and the register-file reset pulse shown on the hex displays.

Parameters:
PC_WIDTH, 32, width of program counter and breakpoint address
COUNT_WIDTH, 16, width of executed-cycle counter
BURST_WIDTH, 8, width of burst length / remaining-steps counter

Ports:
clock  input  1  system clock (50 MHz); all state on rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear: counter to 0, state to IDLE
mode  input  2  00 step, 01 free-run, 10 burst, 11 hold
step_req  input  1  debounced pushbutton level, active-high; rising edge detected internally
tick  input  1  one-clock-wide rate strobe (e.g. 1 Hz), synchronous to clock
burst_len  input  BURST_WIDTH  steps per burst, sampled at burst start
bp_enable  input  1  breakpoint armed
bp_addr  input  PC_WIDTH  breakpoint PC
pc  input  PC_WIDTH  current PC from computer
cpu_enable  output  1  one-cycle enable; computer advances one instruction per pulse
register_reset  output  1  high together with cpu_enable when cycle_count == 0
cycle_count  output  COUNT_WIDTH  executed instructions since reset/clear
state  output  2  IDLE=00, RUN=01, BURST=10, HALT=11
halted  output  1  high in HALT

Behaviour:
- Reset (reset_n=0, async): state=IDLE, cpu_enable=0, register_reset=0, cycle_count=0, remaining=0, step edge register=0, halted=0.
- Edge detect: step_q <= step_req; edge = step_req & ~step_q. Held button gives exactly one edge.
- All outputs are registered. A qualifying event in cycle N gives cpu_enable=1 in cycle N+1 only.
- IDLE:
  - mode 00 + edge -> one pulse, stay IDLE.
  - mode 01 -> RUN next cycle, no pulse.
  - mode 10 + edge -> if burst_len != 0: load remaining=burst_len, go BURST. If burst_len == 0: no-op.
  - mode 11 -> no action.
- RUN:
  - each tick -> one pulse.
  - mode != 01 -> IDLE. The mode check takes priority over a tick in the same cycle, so no pulse is issued.
  - edge ignored.
- BURST:
  - each tick -> one pulse, remaining--.
  - on the tick where remaining == 1: pulse, then IDLE.
  - mode 11 -> abort to IDLE, remaining=0. Other mode changes do not abort.
- Breakpoint (RUN and BURST only):
  - applies when bp_enable=1 and pc == bp_addr at a tick.
  - no pulse is issued; state -> HALT; remaining is preserved.
  - manual step in IDLE ignores the breakpoint, so the user can step past it.
- HALT:
  - halted=1, no pulses.
  - edge -> IDLE with no pulse; a further edge in mode 00 then steps.
  - tick ignored.
- clear=1: state=IDLE, cycle_count=0, remaining=0, no pulse that cycle. clear wins over all simultaneous events.
- cycle_count increments in the same cycle cpu_enable=1 and wraps from all-ones to 0.
- register_reset = cpu_enable & (cycle_count == 0), evaluated on the pre-increment count. It therefore fires on the first instruction after reset/clear and after every wrap.
- Reset asserted mid-burst: immediate IDLE; an in-flight pulse is dropped.

Test Plan:
- Reset, mode=00, press step 3 times (each held 10 cycles) -> exactly 3 cpu_enable pulses, each 1 cycle wide, 1 cycle after each edge. cycle_count=3. register_reset only on the first pulse.
- mode=01, tick every 5 cycles for 50 cycles -> 10 pulses, state=01. Switch mode=00 in the same cycle as a tick -> no pulse, state=00.
- mode=10, burst_len=4, one edge, ticks every 3 cycles -> exactly 4 pulses, then state=00. Repeat with burst_len=0 -> no pulses, state stays 00.
- mode=01, bp_enable=1, bp_addr=0x0C, pc driven 0x00,0x04,0x08,0x0C on successive pulses -> 3 pulses, then HALT with halted=1 and no further pulses. Edge -> IDLE. mode=00 + edge -> 1 pulse despite pc=0x0C.
- Preload cycle_count to 0xFFFF via 65535 pulses (or force), then one step -> cycle_count=0x0000 and register_reset=0. The next step gives register_reset=1 and cycle_count=1.
- Mid-burst (burst_len=8, after 3 pulses): assert clear -> state=00, cycle_count=0, no pulse that cycle. Repeat using reset_n low asynchronously between clock edges -> outputs cleared immediately.
